// File: rtl/sata_cmd_splitter.sv
// sata_cmd_splitter
//
// Command front end for the SATA host wrapper. Takes one transfer request
// (type, start LBA, sector count), cuts it into chunks of at most
// MAX_SECTORS sectors, and issues each chunk over the ready_for_cmd /
// new_cmd handshake. Each wait on the host is guarded by a watchdog.
//
// Parameters
//   MAX_SECTORS  largest sector_count per issued command (power of two)
//   ACK_CYCLES   cycles allowed for ready_for_cmd to fall after new_cmd
//   TIMEOUT      cycles allowed for ready_for_cmd to rise again
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid      request present
//   req_ready      high only while idle; accept = req_valid && req_ready
//   req_type       00 read, 01 write, 10 flush, 11 reserved
//   req_lba        start sector address
//   req_count      total sectors
//   ready_for_cmd  host idle and able to take a command
//   new_cmd        one-cycle issue strobe
//   cmd_type       type of the issued chunk (held until next new_cmd)
//   sector_addr    chunk start LBA (held until next new_cmd)
//   sector_count   chunk length (held until next new_cmd)
//   busy           high from acceptance until done/err
//   done           one-cycle pulse when all chunks have completed
//   err            sticky error flag, cleared by the next accepted request
//   err_code       01 reject, 10 ack timeout, 11 completion timeout
//   chunks_left    chunks still to issue, including the current one
module sata_cmd_splitter #(
    parameter int MAX_SECTORS = 256,
    parameter int ACK_CYCLES  = 16,
    parameter int TIMEOUT     = 1 << 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [31:0] req_lba,
    input  logic [31:0] req_count,
    input  logic        ready_for_cmd,
    output logic        new_cmd,
    output logic [1:0]  cmd_type,
    output logic [31:0] sector_addr,
    output logic [31:0] sector_count,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] chunks_left
);

    localparam int          SHIFT     = $clog2(MAX_SECTORS);
    localparam logic [31:0] MAX_W     = 32'(MAX_SECTORS);
    localparam logic [32:0] MAX_W33   = 33'(MAX_SECTORS);
    localparam logic [32:0] LBA_SPACE = 33'h1_0000_0000;
    // Watchdogs are loaded with N-1 on entry so that expiry lands exactly
    // N cycles after the state was entered.
    localparam logic [31:0] ACK_LOAD  = 32'(ACK_CYCLES - 1);
    localparam logic [31:0] DONE_LOAD = 32'(TIMEOUT - 1);

    localparam logic [1:0] TYPE_FLUSH    = 2'b10;
    localparam logic [1:0] TYPE_RESERVED = 2'b11;

    localparam logic [1:0] ERR_REJECT   = 2'b01;
    localparam logic [1:0] ERR_ACK_TO   = 2'b10;
    localparam logic [1:0] ERR_DONE_TO  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t      state;
    logic [31:0] wd;

    // Latched request: only meaningful after an accept, so no reset.
    logic [1:0]  type_q;
    logic [31:0] lba;
    logic [31:0] remaining;

    logic        accept;
    logic        load_req;
    logic        chunk_done;
    logic        flush_q;
    logic        reject;
    logic [32:0] req_end;
    logic [31:0] req_chunks;

    // Chunk length: the remaining sector count saturated at MAX_SECTORS.
    function automatic logic [31:0] clamp_chunk(input logic [31:0] rem);
        return (rem < MAX_W) ? rem : MAX_W;
    endfunction

    // ceil(count / MAX_SECTORS); the 33-bit sum cannot overflow, and the
    // shifted result always fits back into 32 bits.
    function automatic logic [31:0] ceil_chunks(input logic [31:0] count);
        logic [32:0] rounded;
        rounded = {1'b0, count} + (MAX_W33 - 33'd1);
        return 32'(rounded >> SHIFT);
    endfunction

    assign accept     = req_valid && req_ready;
    assign load_req   = (state == IDLE) && accept;
    assign chunk_done = (state == WAIT_DONE) && ready_for_cmd;
    assign flush_q    = (type_q == TYPE_FLUSH);
    assign busy       = (state != IDLE);

    // The range check is done in 33 bits so that a request ending exactly
    // at the top of the 32-bit LBA space is still legal. Flush ignores its
    // count, so only reads and writes are range checked.
    assign req_end    = {1'b0, req_lba} + {1'b0, req_count};
    assign reject     = (req_type == TYPE_RESERVED) ||
                        ((req_type != TYPE_FLUSH) && (req_end > LBA_SPACE));
    assign req_chunks = ceil_chunks(req_count);

    // Request datapath: loaded on accept, advanced once per completed chunk.
    always_ff @(posedge clk) begin
        if (load_req) begin
            type_q    <= req_type;
            lba       <= req_lba;
            remaining <= req_count;
        end else if (chunk_done) begin
            lba       <= lba + sector_count;
            remaining <= remaining - sector_count;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wd           <= '0;
            req_ready    <= 1'b1;
            new_cmd      <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= 2'b00;
            cmd_type     <= 2'b00;
            sector_addr  <= '0;
            sector_count <= '0;
            chunks_left  <= '0;
        end else begin
            new_cmd <= 1'b0;
            done    <= 1'b0;

            case (state)
                // Idle: take a request, or reject it without leaving IDLE.
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        err      <= 1'b0;
                        err_code <= 2'b00;
                        if (reject) begin
                            err         <= 1'b1;
                            err_code    <= ERR_REJECT;
                            chunks_left <= '0;
                        end else if (req_type == TYPE_FLUSH) begin
                            chunks_left <= 32'd1;
                            req_ready   <= 1'b0;
                            state       <= ISSUE;
                        end else if (req_count == '0) begin
                            chunks_left <= '0;
                            req_ready   <= 1'b0;
                            state       <= FINISH;
                        end else begin
                            chunks_left <= req_chunks;
                            req_ready   <= 1'b0;
                            state       <= ISSUE;
                        end
                    end
                end

                // Issue: no watchdog here; wait as long as the host is busy.
                ISSUE: begin
                    if (ready_for_cmd) begin
                        new_cmd      <= 1'b1;
                        cmd_type     <= type_q;
                        sector_addr  <= lba;
                        sector_count <= flush_q ? 32'd0 : clamp_chunk(remaining);
                        wd           <= ACK_LOAD;
                        state        <= WAIT_ACK;
                    end
                end

                // Wait for the host to drop ready; the edge wins over expiry.
                WAIT_ACK: begin
                    if (!ready_for_cmd) begin
                        wd    <= DONE_LOAD;
                        state <= WAIT_DONE;
                    end else if (wd == '0) begin
                        err      <= 1'b1;
                        err_code <= ERR_ACK_TO;
                        state    <= IDLE;
                    end else begin
                        wd <= wd - 32'd1;
                    end
                end

                // Wait for chunk completion; the edge wins over expiry.
                WAIT_DONE: begin
                    if (ready_for_cmd) begin
                        chunks_left <= chunks_left - 32'd1;
                        if (flush_q || (remaining == sector_count)) begin
                            state <= FINISH;
                        end else begin
                            state <= ISSUE;
                        end
                    end else if (wd == '0) begin
                        err      <= 1'b1;
                        err_code <= ERR_DONE_TO;
                        state    <= IDLE;
                    end else begin
                        wd <= wd - 32'd1;
                    end
                end

                // Finish: one done pulse; req_ready follows a cycle later.
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sata_cmd_splitter.sv
// Testbench for sata_cmd_splitter: directed cases plus randomized requests,
// checked by a scoreboard fed from a request-level reference model.
module tb_sata_cmd_splitter;

    localparam int MAXS   = 256;
    localparam int ACKC   = 16;
    localparam int TMO    = 64;
    localparam int NORMAL = 0;
    localparam int NOACK  = 1;
    localparam int NOCOMP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_type = 2'b00;
    logic [31:0] req_lba = '0;
    logic [31:0] req_count = '0;
    logic        ready_for_cmd;
    logic        new_cmd;
    logic [1:0]  cmd_type;
    logic [31:0] sector_addr;
    logic [31:0] sector_count;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] chunks_left;

    typedef struct packed {
        logic [1:0]  t;
        logic [31:0] a;
        logic [31:0] c;
        logic [31:0] n;
    } cmd_t;

    cmd_t cmd_q[$];
    int   res_q[$];     // 0 = done, 1..3 = expected err_code
    int   cmd_cycs[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_dly = 2;
    int done_dly = 20;
    int host_mode = NORMAL;
    int restore_req = 0;
    int restore_ack = 0;
    int rdy_fall_cyc = 0;
    int done_cyc = -1;
    int err_cyc = -1;
    logic err_prev = 1'b0;
    logic acc_prev = 1'b0;

    sata_cmd_splitter #(
        .MAX_SECTORS(MAXS),
        .ACK_CYCLES (ACKC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_type     (req_type),
        .req_lba      (req_lba),
        .req_count    (req_count),
        .ready_for_cmd(ready_for_cmd),
        .new_cmd      (new_cmd),
        .cmd_type     (cmd_type),
        .sector_addr  (sector_addr),
        .sector_count (sector_count),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .chunks_left  (chunks_left)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    // Reference model: expected commands and final outcome of one request.
    function automatic void model(input logic [1:0] t, input logic [31:0] l,
                                  input logic [31:0] c, input int mode);
        logic [32:0] endp;
        longint rem, a, n, ch;
        cmd_t e;
        int fault;
        fault = (mode == NOACK) ? 2 : ((mode == NOCOMP) ? 3 : 0);
        endp = {1'b0, l} + {1'b0, c};
        if (t == 2'b11 || (t != 2'b10 && endp > 33'h1_0000_0000)) begin
            res_q.push_back(1);
            return;
        end
        if (t == 2'b10) begin
            e.t = 2'b10; e.a = l; e.c = 32'd0; e.n = 32'd1;
            cmd_q.push_back(e);
            res_q.push_back(fault);
            return;
        end
        if (c == 32'd0) begin
            res_q.push_back(0);
            return;
        end
        rem = longint'(c);
        a   = longint'(l);
        n   = (rem + MAXS - 1) / MAXS;
        while (rem > 0) begin
            ch = (rem < MAXS) ? rem : longint'(MAXS);
            e.t = t; e.a = a[31:0]; e.c = ch[31:0]; e.n = n[31:0];
            cmd_q.push_back(e);
            if (mode != NORMAL) begin
                res_q.push_back(fault);
                return;
            end
            a   = a + ch;
            rem = rem - ch;
            n   = n - 1;
        end
        res_q.push_back(0);
    endfunction

    // Host model: acks a command after ack_dly cycles, completes after done_dly.
    initial begin
        ready_for_cmd = 1'b1;
        forever begin
            @(negedge clk);
            if (restore_req != restore_ack) begin
                restore_ack   = restore_req;
                ready_for_cmd = 1'b1;
            end else if (new_cmd && rst_n) begin
                repeat (ack_dly) @(negedge clk);
                if (host_mode != NOACK) begin
                    ready_for_cmd = 1'b0;
                    rdy_fall_cyc  = cyc;
                end
                repeat (done_dly) @(negedge clk);
                if (host_mode == NORMAL) ready_for_cmd = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    initial begin
        cmd_t e;
        int   exp_code;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (new_cmd) begin
                    cmd_cycs.push_back(cyc);
                    if (cmd_q.size() == 0) begin
                        fail("unexpected_new_cmd");
                    end else begin
                        e = cmd_q.pop_front();
                        check("cmd_type",     longint'(cmd_type),     longint'(e.t));
                        check("sector_addr",  longint'(sector_addr),  longint'(e.a));
                        check("sector_count", longint'(sector_count), longint'(e.c));
                        check("chunks_left",  longint'(chunks_left),  longint'(e.n));
                    end
                end
                if (done) begin
                    done_cyc = cyc;
                    if (res_q.size() == 0) begin
                        fail("unexpected_done");
                    end else begin
                        exp_code = res_q.pop_front();
                        check("outcome_done", 0, exp_code);
                    end
                end
                if (err && (!err_prev || acc_prev)) begin
                    err_cyc = cyc;
                    if (res_q.size() == 0) begin
                        fail("unexpected_err");
                    end else begin
                        exp_code = res_q.pop_front();
                        check("outcome_err_code", longint'(err_code), exp_code);
                    end
                end
            end
            err_prev = err;
            acc_prev = req_valid && req_ready;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [1:0] t, input logic [31:0] l,
                          input logic [31:0] c, output int acc);
        int n = 0;
        while (!req_ready && n < 200) begin
            step(1);
            n++;
        end
        if (!req_ready) fail("req_ready_wait_timeout");
        model(t, l, c, host_mode);
        cmd_cycs.delete();
        done_cyc  = -1;
        err_cyc   = -1;
        req_type  = t;
        req_lba   = l;
        req_count = c;
        req_valid = 1'b1;
        step(1);
        req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || !req_ready) && n < budget) begin
            step(1);
            n++;
        end
        if (busy || !req_ready) fail("idle_wait_timeout");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"},    longint'(req_ready),    1);
        check({tag, "_new_cmd"},      longint'(new_cmd),      0);
        check({tag, "_done"},         longint'(done),         0);
        check({tag, "_busy"},         longint'(busy),         0);
        check({tag, "_err"},          longint'(err),          0);
        check({tag, "_err_code"},     longint'(err_code),     0);
        check({tag, "_cmd_type"},     longint'(cmd_type),     0);
        check({tag, "_sector_addr"},  longint'(sector_addr),  0);
        check({tag, "_sector_count"}, longint'(sector_count), 0);
        check({tag, "_chunks_left"},  longint'(chunks_left),  0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish, expected finish within limit");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int acc;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        rst_n = 1'b1;
        step(2);

        // Read 600 sectors -> 256, 256, 88.
        ack_dly = 2; done_dly = 20;
        do_req(2'b00, 32'h1000, 32'd600, acc);
        wait_idle(500);
        check("read600_cmds", cmd_cycs.size(), 3);
        if (cmd_cycs.size() > 0) check("read600_first_latency", cmd_cycs[0] - acc, 1);
        check("read600_hold_addr",  longint'(sector_addr),  32'h1200);
        check("read600_hold_count", longint'(sector_count), 88);
        check("read600_chunks_end", longint'(chunks_left),  0);
        check("read600_err",        longint'(err),          0);

        // Zero-count write.
        do_req(2'b01, 32'h40, 32'd0, acc);
        wait_idle(50);
        check("zero_done_latency", done_cyc - acc, 1);
        check("zero_no_cmd", cmd_cycs.size(), 0);

        // Flush ignores its count.
        do_req(2'b10, 32'hABC, 32'd5, acc);
        wait_idle(200);
        check("flush_cmds", cmd_cycs.size(), 1);
        check("flush_cmd_type", longint'(cmd_type), 2);
        check("flush_count", longint'(sector_count), 0);

        // Rejects, then a valid request clears err.
        do_req(2'b11, 32'h10, 32'd10, acc);
        check("reserved_err", longint'(err), 1);
        check("reserved_code", longint'(err_code), 1);
        check("reserved_req_ready", longint'(req_ready), 1);
        wait_idle(20);
        do_req(2'b00, 32'hFFFF_FF00, 32'h101, acc);
        check("range_err", longint'(err), 1);
        check("range_code", longint'(err_code), 1);
        wait_idle(20);
        check("reject_no_cmd", cmd_cycs.size(), 0);
        do_req(2'b01, 32'h10, 32'd0, acc);
        check("err_cleared", longint'(err), 0);
        wait_idle(50);

        // Request ending exactly at the top of LBA space is legal.
        do_req(2'b00, 32'hFFFF_FF00, 32'h100, acc);
        wait_idle(200);
        check("top_fit_cmds", cmd_cycs.size(), 1);
        check("top_fit_err", longint'(err), 0);

        // Host never acknowledges.
        host_mode = NOACK;
        do_req(2'b00, 32'h500, 32'd100, acc);
        wait_idle(300);
        if (cmd_cycs.size() > 0) check("ack_timeout_cycles", err_cyc - cmd_cycs[0], ACKC);
        else fail("ack_timeout_no_cmd");
        check("ack_timeout_code", longint'(err_code), 2);
        host_mode = NORMAL;
        step(40);

        // Host never completes.
        host_mode = NOCOMP;
        do_req(2'b01, 32'h700, 32'd50, acc);
        wait_idle(500);
        check("done_timeout_cycles", err_cyc - rdy_fall_cyc, TMO + 1);
        check("done_timeout_code", longint'(err_code), 3);
        host_mode = NORMAL;
        restore_req++;
        step(3);

        // Reset during WAIT_DONE of chunk 2.
        do_req(2'b00, 32'h2000, 32'd600, acc);
        n = 0;
        while (!(cmd_cycs.size() >= 2 && !ready_for_cmd) && n < 500) begin
            step(1);
            n++;
        end
        check("midreset_busy", longint'(busy), 1);
        check("midreset_chunks", longint'(chunks_left), 2);
        rst_n = 1'b0;
        cmd_q.delete();
        res_q.delete();
        #1;
        check_reset_values("midreset");
        step(3);
        rst_n = 1'b1;
        step(40);
        do_req(2'b00, 32'h3000, 32'd300, acc);
        wait_idle(300);
        check("post_reset_cmds", cmd_cycs.size(), 2);

        // Randomized requests.
        for (int i = 0; i < 40; i++) begin
            int r;
            logic [1:0]  t;
            logic [31:0] l;
            logic [31:0] c;
            r = $urandom_range(0, 9);
            t = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r == 7) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
            l = $urandom;
            c = $urandom_range(0, 1100);
            if ($urandom_range(0, 7) == 0) c = 32'd0;
            if (r == 9) l = 32'hFFFF_FFFF - $urandom_range(0, 1200);
            ack_dly  = $urandom_range(1, 4);
            done_dly = $urandom_range(1, 30);
            do_req(t, l, c, acc);
            wait_idle(3000);
        end

        step(5);
        check("cmd_queue_drained", cmd_q.size(), 0);
        check("result_queue_drained", res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
